// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Purpose:
//   Moore-style control unit for a multi-cycle RV32I datapath. The datapath
//   shares one PC/IR/ALU/memory path, and this FSM drives it one step per
//   clock. A single unified memory port serves both instruction fetch and
//   data access. Illegal opcodes park the FSM in TRAP with a sticky flag.
//   The block also counts retired instructions.
//
// Handshake (memory port):
//   o_mem_req is held high for every cycle of an access. The access completes
//   in the first cycle where i_mem_ready is sampled high together with
//   o_mem_req. Until then every output stays constant (the state does not
//   change). i_mem_ready is ignored whenever o_mem_req is low.
//   o_mem_we qualifies o_mem_req as a write.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   i_op          opcode from IR (instr[6:0])
//   i_funct3      funct3 from IR (instr[14:12])
//   i_zero        ALU zero flag
//   i_mem_ready   memory completes the current access this cycle
//   o_mem_req     memory access request
//   o_mem_we      write qualifier for o_mem_req
//   o_adr_src     memory address select: 0 = PC, 1 = ALUOut
//   o_ir_we       IR and OldPC load enable
//   o_pc_we       PC load enable
//   o_reg_we      register-file write enable
//   o_alu_src_a   ALU A select: 00 = PC, 01 = OldPC, 10 = rs1
//   o_alu_src_b   ALU B select: 00 = rs2, 01 = imm, 10 = constant 4
//   o_alu_op      ALU class: 00 = add, 01 = sub, 10 = decode by funct
//   o_result_src  result mux: 00 = ALUOut, 01 = data reg, 10 = ALU direct
//   o_illegal     sticky illegal-opcode flag
//   o_instret     retired-instruction count (wraps)
//   o_state_dbg   current state encoding
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       i_op,
  input  logic [2:0]       i_funct3,
  input  logic             i_zero,
  input  logic             i_mem_ready,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic             o_adr_src,
  output logic             o_ir_we,
  output logic             o_pc_we,
  output logic             o_reg_we,
  output logic [1:0]       o_alu_src_a,
  output logic [1:0]       o_alu_src_b,
  output logic [1:0]       o_alu_op,
  output logic [1:0]       o_result_src,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_instret,
  output logic [3:0]       o_state_dbg
);

  // State encoding is visible on o_state_dbg, so the values are fixed.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JALR_ADR = 4'd9,
    S_JAL      = 4'd10,
    S_BEQ      = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  // Opcodes understood by DECODE.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t             r_state;
  state_t             w_next;
  logic               r_illegal;
  logic [CNT_W-1:0]   r_instret;

  // Raw (ungated) strobes from the output decoder.
  logic               w_mem_req;
  logic               w_mem_we;
  logic               w_ir_we;
  logic               w_pc_we;
  logic               w_reg_we;

  // Only funct3[0] matters (beq vs bne); the other bits are carried for
  // completeness of the IR field.
  logic               w_unused_funct3;
  assign w_unused_funct3 = ^i_funct3[2:1];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (i_mem_ready) begin
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        case (i_op)
          OP_LOAD,
          OP_STORE:  w_next = S_MEMADR;
          OP_RTYPE:  w_next = S_EXECR;
          OP_ITYPE:  w_next = S_EXECI;
          OP_JAL:    w_next = S_JAL;
          OP_JALR:   w_next = S_JALR_ADR;
          OP_BRANCH: w_next = S_BEQ;
          default:   w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        w_next = (i_op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        if (i_mem_ready) begin
          w_next = S_MEMWB;
        end
      end
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: begin
        if (i_mem_ready) begin
          w_next = S_FETCH;
        end
      end
      S_EXECR:    w_next = S_ALUWB;
      S_EXECI:    w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_JALR_ADR: w_next = S_JAL;
      S_JAL:      w_next = S_ALUWB;
      S_BEQ:      w_next = S_FETCH;
      S_TRAP:     w_next = S_TRAP;
      // Unused encodings recover to FETCH.
      default:    w_next = S_FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decoder (Moore, plus mem_ready/zero/funct3 where a strobe is
  // conditional on them)
  // ---------------------------------------------------------------------------
  always_comb begin
    w_mem_req    = 1'b0;
    w_mem_we     = 1'b0;
    w_ir_we      = 1'b0;
    w_pc_we      = 1'b0;
    w_reg_we     = 1'b0;
    o_adr_src    = 1'b0;
    o_alu_src_a  = 2'b00;
    o_alu_src_b  = 2'b00;
    o_alu_op     = 2'b00;
    o_result_src = 2'b00;
    case (r_state)
      S_FETCH: begin
        // PC+4 goes straight from the ALU into the PC when the fetch lands.
        w_mem_req    = 1'b1;
        o_adr_src    = 1'b0;
        o_alu_src_a  = 2'b00;
        o_alu_src_b  = 2'b10;
        o_alu_op     = 2'b00;
        o_result_src = 2'b10;
        w_ir_we      = i_mem_ready;
        w_pc_we      = i_mem_ready;
      end
      S_DECODE: begin
        // Speculatively compute OldPC+imm: the branch/JAL target.
        o_alu_src_a = 2'b01;
        o_alu_src_b = 2'b01;
        o_alu_op    = 2'b00;
      end
      S_MEMADR: begin
        o_alu_src_a = 2'b10;
        o_alu_src_b = 2'b01;
        o_alu_op    = 2'b00;
      end
      S_MEMREAD: begin
        w_mem_req = 1'b1;
        o_adr_src = 1'b1;
      end
      S_MEMWB: begin
        o_result_src = 2'b01;
        w_reg_we     = 1'b1;
      end
      S_MEMWRITE: begin
        w_mem_req = 1'b1;
        w_mem_we  = 1'b1;
        o_adr_src = 1'b1;
      end
      S_EXECR: begin
        o_alu_src_a = 2'b10;
        o_alu_src_b = 2'b00;
        o_alu_op    = 2'b10;
      end
      S_EXECI: begin
        o_alu_src_a = 2'b10;
        o_alu_src_b = 2'b01;
        o_alu_op    = 2'b10;
      end
      S_ALUWB: begin
        o_result_src = 2'b00;
        w_reg_we     = 1'b1;
      end
      S_JALR_ADR: begin
        // rs1+imm replaces the DECODE-computed target in ALUOut.
        o_alu_src_a = 2'b10;
        o_alu_src_b = 2'b01;
        o_alu_op    = 2'b00;
      end
      S_JAL: begin
        // PC <- ALUOut (target) while the ALU forms OldPC+4 for the link.
        o_alu_src_a  = 2'b01;
        o_alu_src_b  = 2'b10;
        o_alu_op     = 2'b00;
        o_result_src = 2'b00;
        w_pc_we      = 1'b1;
      end
      S_BEQ: begin
        // funct3[0] inverts the sense of zero: beq takes on equal, bne on
        // not-equal.
        o_alu_src_a  = 2'b10;
        o_alu_src_b  = 2'b00;
        o_alu_op     = 2'b01;
        o_result_src = 2'b00;
        w_pc_we      = i_zero ^ i_funct3[0];
      end
      default: begin
        // TRAP and unused encodings: everything stays at its default.
      end
    endcase
  end

  // Strobes are gated by rst_n so nothing fires (in particular no partial
  // memory write) while reset is held, even though reset lands in FETCH.
  assign o_mem_req = w_mem_req & rst_n;
  assign o_mem_we  = w_mem_we  & rst_n;
  assign o_ir_we   = w_ir_we   & rst_n;
  assign o_pc_we   = w_pc_we   & rst_n;
  assign o_reg_we  = w_reg_we  & rst_n;

  // ---------------------------------------------------------------------------
  // Retired-instruction counter: an instruction retires on the edge that
  // returns the FSM to FETCH from any other state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instret <= '0;
    end else if ((w_next == S_FETCH) && (r_state != S_FETCH) &&
                 (r_state != S_TRAP)) begin
      r_instret <= r_instret + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky illegal-opcode flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal <= 1'b0;
    end else if ((r_state == S_DECODE) && (w_next == S_TRAP)) begin
      r_illegal <= 1'b1;
    end
  end

  assign o_illegal   = r_illegal;
  assign o_instret   = r_instret;
  assign o_state_dbg = r_state;

endmodule
